stage_2_pipe: RTL and testbench
===============================

// Module: stage_2_pipe
// PURPOSE
//   Parametrised, pipelined successor of the encoder's combinational interval-update stage.
//   Per symbol it computes u/v from range and CDF terms, then updates low/range for the COMP / non-COMP paths.
//   Adds a 2-deep registered pipeline with valid/ready flow control.
//   Adds carry-out detection on low and an error flag for a degenerate (zero or wrapped) range.
//   Sits between the CDF/LUT fetch stage and the renormalisation stage of the arithmetic encoder.
// PARAMETERS
//   RANGE_W     16  width of range, UU, VV, lut_u, lut_v
//   LOW_W       16  width of low (in and out); overflow is reported on out_carry
//   RANGE_SHIFT 8   RR = in_range >> RANGE_SHIFT
//   MUL_SHIFT   1   right shift applied to RR*UU and RR*VV before adding the LUT term
// PORTS
//   clk        in   1        clock, all state on rising edge
//   reset      in   1        asynchronous, active-high; clears all state
//   in_valid   in   1        input symbol valid
//   in_ready   out  1        stage can accept; transfer when in_valid & in_ready
//   in_uu      in   RANGE_W  UU term
//   in_vv      in   RANGE_W  VV term
//   in_range   in   RANGE_W  current range
//   in_low     in   LOW_W    current low
//   in_lut_u   in   RANGE_W  additive LUT term for u
//   in_lut_v   in   RANGE_W  additive LUT term for v
//   in_comp    in   1        1: symbol path (low += range-u, range = u-v); 0: range = range-v, low kept
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts; transfer when out_valid & out_ready
//   out_low    out  LOW_W    updated low (truncated)
//   out_range  out  RANGE_W  updated range (truncated)
//   out_carry  out  1        low addition overflowed LOW_W (comp path only)
//   out_error  out  1        resulting range is 0 or wrapped
// BEHAVIOUR
// - Reset: v1 = v2 = 0, out_valid = 0; out_low/out_range/out_carry/out_error = 0; data regs cleared.
// - Arithmetic:
//   - RR = in_range >> RANGE_SHIFT.
//   - Products are full 2*RANGE_W bits.
//   - u = ((RR*UU) >> MUL_SHIFT) + lut_u, truncated to RANGE_W; v likewise with VV and lut_v.
//   - All subtractions are modulo 2^RANGE_W.
// - Stage 1 (S1):
//   - On in transfer, registers u, v, in_range, in_low, in_comp; sets v1.
//   - Multiplications happen before this register.
// - Stage 2 (S2):
//   - Computes from S1 regs and registers the outputs.
//   - comp=1:
//     - low = low + (range - u), carry = bit LOW_W of the (LOW_W+1)-bit sum.
//     - range = u - v, error = (u <= v).
//   - comp=0:
//     - low unchanged, carry = 0.
//     - range = in_range - v, error = (v >= in_range).
// - Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
//   Throughput is 1 symbol/cycle.
// - Flow control:
//   - en2 = ~v2 | out_ready
//   - en1 = ~v1 | en2
//   - in_ready = en1 (combinational from out_ready; no combinational path from in_valid).
//   - S2 loads when en2: v2 <= v1.
//   - S1 loads when en1: v1 <= in_valid.
//   - Holding regs keep their value while not enabled.
// - Stall: out_valid=1 & out_ready=0 holds all outputs stable.
//   S1 keeps filling; at most 2 symbols are in flight.
//   in_ready=0 only when v1 & v2 & ~out_ready.
// - Simultaneous in/out transfer with the pipe full is allowed (bubble-free).
// - No reordering, no dropping, no duplication.
// - Error/carry are informational: data still flows; the downstream stage decides.
// - Reset mid-operation: in-flight symbols are discarded; out_valid drops asynchronously.
// - Products use RANGE_W-bit unsigned operands; the design makes no signed interpretation.
// TESTING
// 1. Reset, comp=1, range=0x8000, UU=0x100, VV=0x40, lut_u=8, lut_v=4, low=0x0100:
//    -> after 2 cycles out_low=0x40F8, out_range=0x3004, carry=0, error=0.
// 2. Same input with comp=0:
//    -> out_range=0x6FFC, out_low=0x0100, carry=0, error=0.
// 3. comp=1, low=0xFFF0, other inputs as test 1:
//    -> out_low=0x3FE8, out_carry=1, out_range=0x3004.
// 4. comp=1, UU=VV=0x40, lut_u=lut_v=4:
//    -> out_range=0x0000, out_error=1.
// 5. Stream 5 distinct symbols, out_ready=0 for cycles 2..5:
//    -> in_ready low while the pipe is full, outputs stable, all 5 emerge in order, none lost.
// 6. Assert reset with 2 symbols in flight:
//    -> out_valid=0 immediately; after release, 1 new symbol appears 2 cycles after its acceptance.

Source files
------------

// File: rtl/stage_2_pipe.sv
// stage_2_pipe: pipelined interval-update stage of the arithmetic encoder.
// S1 registers the scaled u/v terms plus the symbol context. S2 applies the
// COMP / non-COMP low/range update and registers the results, along with
// carry-out and degenerate-range flags. The valid/ready handshake is
// bubble-free, and at most two symbols are in flight at any time.
module stage_2_pipe #(
  parameter int RANGE_W     = 16,
  parameter int LOW_W       = 16,
  parameter int RANGE_SHIFT = 8,
  parameter int MUL_SHIFT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RANGE_W-1:0] in_uu,
  input  logic [RANGE_W-1:0] in_vv,
  input  logic [RANGE_W-1:0] in_range,
  input  logic [LOW_W-1:0]   in_low,
  input  logic [RANGE_W-1:0] in_lut_u,
  input  logic [RANGE_W-1:0] in_lut_v,
  input  logic               in_comp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOW_W-1:0]   out_low,
  output logic [RANGE_W-1:0] out_range,
  output logic               out_carry,
  output logic               out_error
);

  localparam int PROD_W = 2 * RANGE_W;

  // Scaled CDF term: ((rr * term) >> MUL_SHIFT) + lut, truncated to RANGE_W.
  // The product is formed at full width so that no bit is lost before the shift.
  function automatic logic [RANGE_W-1:0] scale_term(
    input logic [RANGE_W-1:0] rr,
    input logic [RANGE_W-1:0] term,
    input logic [RANGE_W-1:0] lut
  );
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shifted;
    prod    = {{RANGE_W{1'b0}}, rr} * {{RANGE_W{1'b0}}, term};
    shifted = prod >> MUL_SHIFT;
    return shifted[RANGE_W-1:0] + lut;
  endfunction

  logic [RANGE_W-1:0] rr_s;
  logic [RANGE_W-1:0] u_s;
  logic [RANGE_W-1:0] v_s;
  logic               en1_s;
  logic               en2_s;

  logic               v1_r;
  logic               v2_r;
  logic [RANGE_W-1:0] u_r;
  logic [RANGE_W-1:0] v_r;
  logic [RANGE_W-1:0] range_r;
  logic [LOW_W-1:0]   low_r;
  logic               comp_r;

  logic [LOW_W:0]     low_sum_s;
  logic [LOW_W-1:0]   nxt_low_s;
  logic [RANGE_W-1:0] nxt_range_s;
  logic               nxt_carry_s;
  logic               nxt_error_s;

  // Scale range and form u/v ahead of the S1 register.
  always_comb begin
    rr_s = in_range >> RANGE_SHIFT;
    u_s  = scale_term(rr_s, in_uu, in_lut_u);
    v_s  = scale_term(rr_s, in_vv, in_lut_v);
  end

  // Handshake enables. in_ready depends on out_ready and state, but not on in_valid.
  always_comb begin
    en2_s    = ~v2_r | out_ready;
    en1_s    = ~v1_r | en2_s;
    in_ready = en1_s;
  end

  assign out_valid = v2_r;

  // S1: capture u/v and the symbol context on every input transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r    <= 1'b0;
      u_r     <= {RANGE_W{1'b0}};
      v_r     <= {RANGE_W{1'b0}};
      range_r <= {RANGE_W{1'b0}};
      low_r   <= {LOW_W{1'b0}};
      comp_r  <= 1'b0;
    end else if (en1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        u_r     <= u_s;
        v_r     <= v_s;
        range_r <= in_range;
        low_r   <= in_low;
        comp_r  <= in_comp;
      end
    end
  end

  // S2 datapath: COMP path moves low and narrows range to u-v; the other path trims range by v.
  always_comb begin
    low_sum_s   = {1'b0, low_r} + (LOW_W + 1)'(range_r - u_r);
    nxt_low_s   = low_r;
    nxt_range_s = range_r;
    nxt_carry_s = 1'b0;
    nxt_error_s = 1'b0;
    if (comp_r) begin
      nxt_low_s   = low_sum_s[LOW_W-1:0];
      nxt_carry_s = low_sum_s[LOW_W];
      nxt_range_s = u_r - v_r;
      nxt_error_s = (u_r <= v_r);
    end else begin
      nxt_low_s   = low_r;
      nxt_carry_s = 1'b0;
      nxt_range_s = range_r - v_r;
      nxt_error_s = (v_r >= range_r);
    end
  end

  // S2: register results. While stalled, the outputs stay unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r      <= 1'b0;
      out_low   <= {LOW_W{1'b0}};
      out_range <= {RANGE_W{1'b0}};
      out_carry <= 1'b0;
      out_error <= 1'b0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        out_low   <= nxt_low_s;
        out_range <= nxt_range_s;
        out_carry <= nxt_carry_s;
        out_error <= nxt_error_s;
      end
    end
  end

endmodule

// File: tb/tb_stage_2_pipe.sv
// Directed bench for stage_2_pipe, with a scoreboard of expected results.
module tb_stage_2_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_uu, in_vv, in_range, in_low, in_lut_u, in_lut_v;
  logic        in_comp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_low, out_range;
  logic        out_carry, out_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [33:0] sb_q[$];

  stage_2_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uu(in_uu), .in_vv(in_vv), .in_range(in_range), .in_low(in_low),
    .in_lut_u(in_lut_u), .in_lut_v(in_lut_v), .in_comp(in_comp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_low(out_low), .out_range(out_range),
    .out_carry(out_carry), .out_error(out_error)
  );

  always #5 clk = ~clk;

  // Reference model: {carry, error, low, range}
  function automatic logic [33:0] model(input logic [15:0] rng, input logic [15:0] low,
                                        input logic [15:0] uu, input logic [15:0] vv,
                                        input logic [15:0] lu, input logic [15:0] lv,
                                        input logic comp);
    longint rr, u, v, r, l;
    logic c, e;
    rr = longint'(rng) / 256;
    u  = (((rr * longint'(uu)) / 2) + longint'(lu)) % 65536;
    v  = (((rr * longint'(vv)) / 2) + longint'(lv)) % 65536;
    if (comp) begin
      l = longint'(low) + ((longint'(rng) - u + 65536) % 65536);
      c = (l >= 65536);
      l = l % 65536;
      r = (u - v + 65536) % 65536;
      e = (u <= v);
    end else begin
      l = longint'(low);
      c = 1'b0;
      r = (longint'(rng) - v + 65536) % 65536;
      e = (v >= longint'(rng));
    end
    return {c, e, l[15:0], r[15:0]};
  endfunction

  function automatic logic [33:0] observed();
    return {out_carry, out_error, out_low, out_range};
  endfunction

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL sb_underflow observed=%h expected=<none>", observed());
        end else begin
          check("sb_data", observed(), sb_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(in_range, in_low, in_uu, in_vv, in_lut_u, in_lut_v, in_comp));
    end
  end

  task automatic drive(input logic [15:0] rng, input logic [15:0] low,
                       input logic [15:0] uu, input logic [15:0] vv,
                       input logic [15:0] lu, input logic [15:0] lv, input logic comp);
    in_valid = 1'b1;
    in_range = rng; in_low = low; in_uu = uu; in_vv = vv;
    in_lut_u = lu; in_lut_v = lv; in_comp = comp;
  endtask

  // Send one symbol into an empty pipe and check the 2-cycle latency and the result
  task automatic single(input string tag,
                        input logic [15:0] rng, input logic [15:0] low,
                        input logic [15:0] uu, input logic [15:0] vv,
                        input logic [15:0] lu, input logic [15:0] lv, input logic comp,
                        input logic [33:0] exp);
    drive(rng, low, uu, vv, lu, lv, comp);
    #1;
    check({tag, "_in_ready"}, {33'd0, in_ready}, {33'd0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_c1"}, {33'd0, out_valid}, {33'd0, 1'b0});
    @(posedge clk); #1;
    check({tag, "_valid_c2"}, {33'd0, out_valid}, {33'd0, 1'b1});
    check({tag, "_data"}, observed(), exp);
  endtask

  logic [15:0] s_rng [5];
  logic [15:0] s_low [5];
  logic [15:0] s_uu  [5];
  logic [15:0] s_vv  [5];
  logic [15:0] s_lu  [5];
  logic [15:0] s_lv  [5];
  logic        s_cmp [5];
  logic [33:0] s0_exp;
  logic [33:0] c_exp;
  int          idx;
  int          base;
  logic        rdy_exp;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_uu = 16'h0; in_vv = 16'h0; in_range = 16'h0; in_low = 16'h0;
    in_lut_u = 16'h0; in_lut_v = 16'h0; in_comp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, observed()}, 35'd0);
    check("reset_in_ready", {33'd0, in_ready}, {33'd0, 1'b1});
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: COMP path
    single("t1", 16'h8000, 16'h0100, 16'h0100, 16'h0040, 16'h0008, 16'h0004, 1'b1,
           {1'b0, 1'b0, 16'h40F8, 16'h3004});
    // 2: non-COMP path
    single("t2", 16'h8000, 16'h0100, 16'h0100, 16'h0040, 16'h0008, 16'h0004, 1'b0,
           {1'b0, 1'b0, 16'h0100, 16'h6FFC});
    // 3: carry out of low
    single("t3", 16'h8000, 16'hFFF0, 16'h0100, 16'h0040, 16'h0008, 16'h0004, 1'b1,
           {1'b1, 1'b0, 16'h3FE8, 16'h3004});
    // 4: zero range flags an error
    single("t4", 16'h8000, 16'h0100, 16'h0040, 16'h0040, 16'h0004, 16'h0004, 1'b1,
           {1'b0, 1'b1, 16'h70FC, 16'h0000});
    @(posedge clk); #1;

    // 5: stream five symbols with out_ready low in cycles 2..5
    for (int k = 0; k < 5; k++) begin
      s_rng[k] = 16'h4000 + 16'(k) * 16'h0C00;
      s_low[k] = 16'(k) * 16'h3333 + 16'h0011;
      s_uu[k]  = 16'h0020 + 16'(k) * 16'h0030;
      s_vv[k]  = 16'h0010 + 16'(k) * 16'h0008;
      s_lu[k]  = 16'(k);
      s_lv[k]  = 16'h0001;
      s_cmp[k] = (k % 2 == 0);
    end
    s0_exp = model(s_rng[0], s_low[0], s_uu[0], s_vv[0], s_lu[0], s_lv[0], s_cmp[0]);
    idx  = 0;
    base = n_out;
    for (int c = 0; c < 40 && (n_out - base) < 5; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      if (idx < 5) drive(s_rng[idx], s_low[idx], s_uu[idx], s_vv[idx], s_lu[idx], s_lv[idx], s_cmp[idx]);
      else in_valid = 1'b0;
      #3;
      if (c <= 6) begin
        rdy_exp = !(c >= 2 && c <= 5);
        check("t5_in_ready", {33'd0, in_ready}, {33'd0, rdy_exp});
      end
      if (c >= 2 && c <= 5) begin
        check("t5_stall_valid", {33'd0, out_valid}, {33'd0, 1'b1});
        check("t5_stall_data", observed(), s0_exp);
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t5_count", 34'(n_out - base), 34'd5);
    @(posedge clk); #1;

    // 6: reset with two symbols in flight
    drive(16'h9000, 16'h1234, 16'h0050, 16'h0020, 16'h0002, 16'h0001, 1'b1);
    @(posedge clk); #1;
    drive(16'hA000, 16'h4321, 16'h0060, 16'h0030, 16'h0003, 16'h0002, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t6_full_valid", {33'd0, out_valid}, {33'd0, 1'b1});
    reset = 1'b1;
    #1;
    check("t6_reset_async", {out_valid, observed()}, 35'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_after_reset_valid", {33'd0, out_valid}, {33'd0, 1'b0});
    c_exp = model(16'hC000, 16'h0F0F, 16'h0070, 16'h0010, 16'h0005, 16'h0006, 1'b1);
    single("t6_new", 16'hC000, 16'h0F0F, 16'h0070, 16'h0010, 16'h0005, 16'h0006, 1'b1, c_exp);
    repeat (2) @(posedge clk);
    #1;
    check("final_outputs", 34'(n_out), 34'd10);
    check("final_queue_empty", 34'(sb_q.size()), 34'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
